// File: rtl/ser_pkg.sv
// Shared state encoding and constants for the word serializer.
package ser_pkg;

    localparam logic S_IDLE_ENC  = 1'b0;
    localparam logic S_SHIFT_ENC = 1'b1;

    typedef enum logic {
        S_IDLE  = S_IDLE_ENC,
        S_SHIFT = S_SHIFT_ENC
    } ser_state_e;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry word buffer with full flag; a write in the same cycle as a read keeps it full.
module word_hold_buf
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = wr_en_i ? wr_data_i : data_q;
        full_d = wr_en_i | (full_q & ~rd_en_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign rd_data_o = data_q;
    assign full_o    = full_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel words in over valid/ready, gapless registered serial stream out.
//   state   | meaning
//   S_IDLE  | shifter empty, bit_out parked at IDLE_BIT
//   S_SHIFT | shifter holds a word; cnt_q indexes the bit on bit_out
module word_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             shift_en_i,
    output logic             bit_out_o,
    output logic             bit_valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             bit_out_q, bit_out_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept, last, free_slot;
    logic             load_hold, load_direct, hold_wr;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // The shifter can take a new word when idle or while its last bit goes out.
    assign accept      = in_valid_i & ~hold_full;
    assign last        = (state_q == S_SHIFT) & (cnt_q == CNT_LAST) & shift_en_i;
    assign free_slot   = (state_q == S_IDLE) | last;
    assign load_hold   = free_slot & hold_full;
    assign load_direct = free_slot & ~hold_full & accept;
    assign hold_wr     = accept & ~load_direct;
    assign load_word   = hold_full ? hold_data : in_data_i;

    word_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (hold_wr),
        .wr_data_i (in_data_i),
        .rd_en_i   (load_hold),
        .rd_data_o (hold_data),
        .full_o    (hold_full)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bit_out_d = bit_out_q;
        if (load_hold || load_direct) begin
            state_d   = S_SHIFT;
            cnt_d     = '0;
            shreg_d   = drop_bit(load_word);
            bit_out_d = first_bit(load_word);
        end else if ((state_q == S_SHIFT) && shift_en_i) begin
            if (last) begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                bit_out_d = IDLE_BIT;
            end else begin
                cnt_d     = cnt_q + CNT_W'(1);
                shreg_d   = drop_bit(shreg_q);
                bit_out_d = first_bit(shreg_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bit_out_q <= IDLE_BIT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bit_out_q <= bit_out_d;
        end
    end

    assign in_ready_o  = ~hold_full;
    assign bit_out_o   = bit_out_q;
    assign bit_valid_o = (state_q == S_SHIFT) & shift_en_i;
    assign word_done_o = last;
    assign busy_o      = (state_q == S_SHIFT) | hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: MSB-first and LSB-first instances share stimulus and are
// checked each cycle against a queue-of-bits reference model plus directed stream checks.
module tb_word_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'b0000;
    logic       in_valid = 1'b0;
    logic       shift_en = 1'b1;

    logic rdy_m, bo_m, bv_m, wd_m, busy_m;
    logic rdy_l, bo_l, bv_l, wd_l, busy_l;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: bits still owed, in output order, with a last-bit marker.
    logic exp_m[$];
    logic exp_l[$];
    logic exp_last[$];
    int   words = 0;
    logic acc = 1'b0;

    logic [9:0] obs, expv, msk;

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(rdy_m), .shift_en_i(shift_en), .bit_out_o(bo_m),
        .bit_valid_o(bv_m), .word_done_o(wd_m), .busy_o(busy_m)
    );

    word_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(rdy_l), .shift_en_i(shift_en), .bit_out_o(bo_l),
        .bit_valid_o(bv_l), .word_done_o(wd_l), .busy_o(busy_l)
    );

    task automatic reset_model();
        exp_m.delete();
        exp_l.delete();
        exp_last.delete();
        words = 0;
        acc = 1'b0;
    endtask

    // Sample at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        logic ev, ed, eb_m, eb_l, mb;
        @(negedge clk);
        cyc++;
        obs  = {bv_m, wd_m, rdy_m, busy_m, bo_m, bv_l, wd_l, rdy_l, busy_l, bo_l};
        ev   = (exp_m.size() > 0) && shift_en;
        ed   = ev ? exp_last[0] : 1'b0;
        eb_m = ev ? exp_m[0] : 1'b0;
        eb_l = ev ? exp_l[0] : 1'b0;
        mb   = ev || (exp_m.size() == 0);
        expv = {ev, ed, (words < 2), (words > 0), eb_m, ev, ed, (words < 2), (words > 0), eb_l};
        msk  = {4'b1111, mb, 4'b1111, mb};
        @(posedge clk);
        acc = in_valid && (words < 2);
        if (ev) begin
            if (exp_last[0]) words--;
            void'(exp_m.pop_front());
            void'(exp_l.pop_front());
            void'(exp_last.pop_front());
        end
        if (acc) begin
            words++;
            for (int b = 3; b >= 0; b--) exp_m.push_back(in_data[b]);
            for (int b = 0; b <= 3; b++) exp_l.push_back(in_data[b]);
            for (int b = 0; b <= 3; b++) exp_last.push_back(b == 3);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({bv_m, wd_m, rdy_m, busy_m, bo_m} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_msb got=%b expected=00100", {bv_m, wd_m, rdy_m, busy_m, bo_m});
        end
        vectors++;
        if ({bv_l, wd_l, rdy_l, busy_l, bo_l} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_lsb got=%b expected=00100", {bv_l, wd_l, rdy_l, busy_l, bo_l});
        end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        vectors++;
        if ((obs & msk) !== (expv & msk)) begin
            miscompares++;
            $display("FAIL reset_idle cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
        end
    endtask

    task automatic test_single_word();
        logic [3:0] s = 4'b0000;
        int nv = 0;
        int done_at = -1;
        in_data  = 4'b1010;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            in_valid = 1'b0;
            vectors++;
            if ((obs & msk) !== (expv & msk)) begin
                miscompares++;
                $display("FAIL single_word cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
            end
            if (obs[9]) begin
                s = {s[2:0], obs[5]};
                if (obs[8]) done_at = nv;
                nv++;
            end
        end
        vectors++;
        if (s !== 4'b1010 || nv != 4 || done_at != 3) begin
            miscompares++;
            $display("FAIL single_stream got=%b/%0d/%0d expected=1010/4/3", s, nv, done_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] wl [2];
        logic [7:0] s = 8'h00;
        int k = 0;
        int nv = 0;
        int first_v = -1;
        int last_v = -1;
        logic saw_full = 1'b0;
        wl[0] = 4'b0110;
        wl[1] = 4'b1011;
        in_data  = wl[0];
        in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (acc) begin
                k++;
                if (k < 2) in_data = wl[k];
                else in_valid = 1'b0;
            end
            vectors++;
            if ((obs & msk) !== (expv & msk)) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
            end
            if (!obs[7]) saw_full = 1'b1;
            if (obs[9]) begin
                s = {s[6:0], obs[5]};
                if (first_v < 0) first_v = i;
                last_v = i;
                nv++;
            end
        end
        vectors++;
        if (s !== 8'b01101011 || nv != 8 || (last_v - first_v) != 7 || !saw_full) begin
            miscompares++;
            $display("FAIL b2b_stream got=%b n=%0d span=%0d ready_drop=%b expected=01101011 n=8 span=7 ready_drop=1",
                     s, nv, last_v - first_v, saw_full);
        end
    endtask

    task automatic test_stall();
        logic [3:0] s = 4'b0000;
        int nv = 0;
        int nd = 0;
        int done_at = -1;
        int stalls = 0;
        int gap = 0;
        in_data  = 4'b1100;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            in_valid = 1'b0;
            vectors++;
            if ((obs & msk) !== (expv & msk)) begin
                miscompares++;
                $display("FAIL stall cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
            end
            if (obs[9]) begin
                s = {s[2:0], obs[5]};
                if (obs[8]) begin
                    nd++;
                    done_at = nv;
                end
                nv++;
            end else if (nv == 2) begin
                gap++;
            end
            if (nv == 2 && stalls < 3) begin
                shift_en = 1'b0;
                stalls++;
            end else begin
                shift_en = 1'b1;
            end
        end
        vectors++;
        if (s !== 4'b1100 || nv != 4 || nd != 1 || done_at != 3 || gap != 3) begin
            miscompares++;
            $display("FAIL stall_stream got=%b n=%0d done=%0d@%0d gap=%0d expected=1100 n=4 done=1@3 gap=3",
                     s, nv, nd, done_at, gap);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] s = 4'b0000;
        int nv = 0;
        in_data  = 4'b1110;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            in_valid = 1'b0;
            vectors++;
            if ((obs & msk) !== (expv & msk)) begin
                miscompares++;
                $display("FAIL pre_reset cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bv_m, wd_m, rdy_m, busy_m, bo_m, bv_l, wd_l, rdy_l, busy_l, bo_l} !== 10'b0010000100) begin
            miscompares++;
            $display("FAIL mid_reset got=%b expected=0010000100",
                     {bv_m, wd_m, rdy_m, busy_m, bo_m, bv_l, wd_l, rdy_l, busy_l, bo_l});
        end
        reset_model();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_data  = 4'b0101;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            in_valid = 1'b0;
            vectors++;
            if ((obs & msk) !== (expv & msk)) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
            end
            if (obs[9]) begin
                s = {s[2:0], obs[5]};
                nv++;
            end
        end
        vectors++;
        if (s !== 4'b0101 || nv != 4) begin
            miscompares++;
            $display("FAIL post_reset_stream got=%b n=%0d expected=0101 n=4", s, nv);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] s = 4'b0000;
        int nv = 0;
        in_data  = 4'b0001;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            in_valid = 1'b0;
            vectors++;
            if ((obs & msk) !== (expv & msk)) begin
                miscompares++;
                $display("FAIL lsb_first cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
            end
            if (obs[4]) begin
                s = {s[2:0], obs[0]};
                nv++;
            end
        end
        vectors++;
        if (s !== 4'b1000 || nv != 4) begin
            miscompares++;
            $display("FAIL lsb_stream got=%b n=%0d expected=1000 n=4", s, nv);
        end
    endtask

    task automatic test_random();
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = 4'($urandom_range(0, 15));
            end
            shift_en = (i >= 388) || ($urandom_range(0, 3) != 0);
            if (i >= 388) in_valid = 1'b0;
            cycle();
            vectors++;
            if ((obs & msk) !== (expv & msk)) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b expected=%b", cyc, obs & msk, expv & msk);
            end
        end
        vectors++;
        if (words != 0 || bv_m !== 1'b0 || busy_m !== 1'b0) begin
            miscompares++;
            $display("FAIL random_drain got=words%0d/bv%b/busy%b expected=words0/bv0/busy0",
                     words, bv_m, busy_m);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_lsb_first();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
